// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with arbitrary depth, configurable almost-full
// and almost-empty thresholds, an occupancy count and an optional FWFT read port.
module sync_fifo_param #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 1,
  parameter int FWFT       = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [FIFO_WIDTH-1:0]              data_in,
  input  logic                               wr_en,
  input  logic                               rd_en,
  output logic [FIFO_WIDTH-1:0]              data_out,
  output logic                               wr_ack,
  output logic                               overflow,
  output logic                               underflow,
  output logic                               full,
  output logic                               empty,
  output logic                               almostfull,
  output logic                               almostempty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  wr_acc, rd_acc;

  assign full        = (count == CW'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign almostfull  = (count >= CW'(AF_THRESH));
  assign almostempty = (count <= CW'(AE_THRESH));

  // A write into a full FIFO is still taken when the head leaves on the same edge.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_en);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= wr_acc;
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
      if (wr_acc) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head is always presented; only meaningful while not empty.
      assign data_out = mem[rd_ptr];
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] dout_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dout_q <= '0;
        else if (rd_acc) dout_q <= mem[rd_ptr];
      end
      assign data_out = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: three instances (depth 8 standard, depth 5 standard,
// depth 8 FWFT) each shadowed by a queue-based reference model.
module tb_sync_fifo_param;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] din = '0;
  logic        we [3];
  logic        re [3];
  logic [15:0] dout [3];
  logic        ack [3], ovf [3], udf [3], fl [3], em [3], af [3], ae [3];
  logic [3:0]  cnt0, cnt2;
  logic [2:0]  cnt1;

  int total = 0;
  int bad   = 0;

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];
  logic [15:0] dout_e [3];
  bit          ack_e [3], ovf_e [3], udf_e [3];

  always #5 clk = ~clk;

  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .wr_en(we[0]), .rd_en(re[0]),
    .data_out(dout[0]), .wr_ack(ack[0]), .overflow(ovf[0]), .underflow(udf[0]),
    .full(fl[0]), .empty(em[0]), .almostfull(af[0]), .almostempty(ae[0]), .count(cnt0));

  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(5)) u_d5 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .wr_en(we[1]), .rd_en(re[1]),
    .data_out(dout[1]), .wr_ack(ack[1]), .overflow(ovf[1]), .underflow(udf[1]),
    .full(fl[1]), .empty(em[1]), .almostfull(af[1]), .almostempty(ae[1]), .count(cnt1));

  sync_fifo_param #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_fw (
    .clk(clk), .rst_n(rst_n), .data_in(din), .wr_en(we[2]), .rd_en(re[2]),
    .data_out(dout[2]), .wr_ack(ack[2]), .overflow(ovf[2]), .underflow(udf[2]),
    .full(fl[2]), .empty(em[2]), .almostfull(af[2]), .almostempty(ae[2]), .count(cnt2));

  function automatic int msize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [15:0] mhead(input int k);
    case (k)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  function automatic int act_cnt(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  // Reference: a read leaves first, then a write joins the tail.
  task automatic mstep(inout logic [15:0] q [$], input int depth, input int k,
                       input bit w, input bit r, input logic [15:0] d);
    bit wa, ra;
    ra = r && (q.size() > 0);
    wa = w && ((q.size() < depth) || r);
    if (ra) dout_e[k] = q.pop_front();
    if (wa) q.push_back(d);
    ack_e[k] = wa;
    ovf_e[k] = w && !wa;
    udf_e[k] = r && !ra;
  endtask

  task automatic tick();
    @(posedge clk);
    mstep(q0, 8, 0, we[0], re[0], din);
    mstep(q1, 5, 1, we[1], re[1], din);
    mstep(q2, 8, 2, we[2], re[2], din);
    #1;
  endtask

  task automatic idle();
    for (int k = 0; k < 3; k++) begin we[k] = 1'b0; re[k] = 1'b0; end
  endtask

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    for (int k = 0; k < 3; k++) begin
      dout_e[k] = '0; ack_e[k] = 0; ovf_e[k] = 0; udf_e[k] = 0;
    end
  endtask

  task automatic test_reset();
    idle();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", cnt0); end
    total++; if (em[0] !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b want=1", em[0]); end
    total++; if (ae[0] !== 1'b1) begin bad++; $display("FAIL reset_almostempty got=%0b want=1", ae[0]); end
    total++; if (fl[0] !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", fl[0]); end
    total++; if (af[0] !== 1'b0) begin bad++; $display("FAIL reset_almostfull got=%0b want=0", af[0]); end
    total++; if (dout[0] !== 16'h0) begin bad++; $display("FAIL reset_data_out got=%0h want=0", dout[0]); end
    total++; if ({ack[0], ovf[0], udf[0]} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%0b want=000", {ack[0], ovf[0], udf[0]}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      we[0] = 1'b1; din = 16'(i);
      tick();
      total++; if (ack[0] !== 1'b1) begin bad++; $display("FAIL fill_ack[%0d] got=%0b want=1", i, ack[0]); end
      total++; if (cnt0 !== 4'(i)) begin bad++; $display("FAIL fill_count[%0d] got=%0d want=%0d", i, cnt0, i); end
      total++; if (af[0] !== (i >= 6)) begin bad++; $display("FAIL fill_almostfull[%0d] got=%0b want=%0b", i, af[0], i >= 6); end
      total++; if (fl[0] !== (i == 8)) begin bad++; $display("FAIL fill_full[%0d] got=%0b want=%0b", i, fl[0], i == 8); end
    end
    din = 16'hDEAD;
    tick();
    we[0] = 1'b0;
    total++; if (ovf[0] !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%0b want=1", ovf[0]); end
    total++; if (ack[0] !== 1'b0) begin bad++; $display("FAIL ovf_ack got=%0b want=0", ack[0]); end
    total++; if (cnt0 !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d want=8", cnt0); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      re[0] = 1'b1;
      tick();
      total++; if (dout[0] !== 16'(i)) begin bad++; $display("FAIL drain_data[%0d] got=%0h want=%0h", i, dout[0], i); end
      total++; if (ae[0] !== ((8 - i) <= 1)) begin bad++; $display("FAIL drain_almostempty[%0d] got=%0b want=%0b", i, ae[0], (8 - i) <= 1); end
      total++; if (em[0] !== (i == 8)) begin bad++; $display("FAIL drain_empty[%0d] got=%0b want=%0b", i, em[0], i == 8); end
    end
    tick();
    re[0] = 1'b0;
    total++; if (udf[0] !== 1'b1) begin bad++; $display("FAIL udf_pulse got=%0b want=1", udf[0]); end
    total++; if (dout[0] !== 16'h0008) begin bad++; $display("FAIL udf_hold got=%0h want=8", dout[0]); end
  endtask

  task automatic test_wrap();
    int n [4] = '{3, 3, 5, 5};
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < n[ph]; i++) begin
        we[1] = (ph % 2 == 0); re[1] = (ph % 2 == 1); din = 16'($urandom);
        tick();
        if (ph % 2 == 1) begin
          total++; if (dout[1] !== dout_e[1]) begin bad++; $display("FAIL wrap_data[%0d.%0d] got=%0h want=%0h", ph, i, dout[1], dout_e[1]); end
        end
      end
      total++; if (act_cnt(1) !== msize(1)) begin bad++; $display("FAIL wrap_count[%0d] got=%0d want=%0d", ph, act_cnt(1), msize(1)); end
    end
    total++; if (fl[1] !== 1'b0 || em[1] !== 1'b1) begin bad++; $display("FAIL wrap_flags got=%0b%0b want=01", fl[1], em[1]); end
    idle();
  endtask

  task automatic test_simultaneous();
    logic [15:0] head;
    for (int i = 0; i < 8; i++) begin
      we[0] = 1'b1; din = 16'($urandom_range(1, 16'hFFFF));
      tick();
    end
    head = mhead(0);
    re[0] = 1'b1; din = 16'h7E57;
    tick();
    total++; if (cnt0 !== 4'd8) begin bad++; $display("FAIL both_full_count got=%0d want=8", cnt0); end
    total++; if (ack[0] !== 1'b1) begin bad++; $display("FAIL both_full_ack got=%0b want=1", ack[0]); end
    total++; if (dout[0] !== head) begin bad++; $display("FAIL both_full_head got=%0h want=%0h", dout[0], head); end
    we[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (dout[0] !== dout_e[0]) begin bad++; $display("FAIL both_drain[%0d] got=%0h want=%0h", i, dout[0], dout_e[0]); end
    end
    total++; if (dout[0] !== 16'h7E57) begin bad++; $display("FAIL both_tail got=%0h want=7e57", dout[0]); end
    we[0] = 1'b1; din = 16'h1234;
    tick();
    total++; if (cnt0 !== 4'd1) begin bad++; $display("FAIL both_empty_count got=%0d want=1", cnt0); end
    total++; if (udf[0] !== 1'b1) begin bad++; $display("FAIL both_empty_udf got=%0b want=1", udf[0]); end
    we[0] = 1'b0;
    tick();
    idle();
    total++; if (dout[0] !== 16'h1234) begin bad++; $display("FAIL both_empty_data got=%0h want=1234", dout[0]); end
  endtask

  task automatic test_fwft();
    we[2] = 1'b1; din = 16'hABCD;
    tick();
    we[2] = 1'b0;
    total++; if (dout[2] !== 16'hABCD) begin bad++; $display("FAIL fwft_data got=%0h want=abcd", dout[2]); end
    total++; if (em[2] !== 1'b0) begin bad++; $display("FAIL fwft_not_empty got=%0b want=0", em[2]); end
    tick();
    total++; if (dout[2] !== 16'hABCD) begin bad++; $display("FAIL fwft_hold got=%0h want=abcd", dout[2]); end
    re[2] = 1'b1;
    tick();
    re[2] = 1'b0;
    total++; if (em[2] !== 1'b1) begin bad++; $display("FAIL fwft_pop_empty got=%0b want=1", em[2]); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) begin
      we[0] = 1'b1; we[1] = 1'b1; din = 16'h0100 + 16'(i);
      tick();
    end
    idle();
    total++; if (cnt0 !== 4'd4) begin bad++; $display("FAIL areset_pre_count got=%0d want=4", cnt0); end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    total++; if (cnt0 !== 4'd0) begin bad++; $display("FAIL areset_count got=%0d want=0", cnt0); end
    total++; if (em[0] !== 1'b1 || ae[0] !== 1'b1) begin bad++; $display("FAIL areset_empty got=%0b%0b want=11", em[0], ae[0]); end
    total++; if (ack[0] !== 1'b0) begin bad++; $display("FAIL areset_ack got=%0b want=0", ack[0]); end
    total++; if (dout[0] !== 16'h0) begin bad++; $display("FAIL areset_data_out got=%0h want=0", dout[0]); end
    total++; if (cnt1 !== 3'd0) begin bad++; $display("FAIL areset_count_d5 got=%0d want=0", cnt1); end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      we[1] = 1'b1; din = 16'h0A00 + 16'(i);
      tick();
    end
    idle();
    total++; if (fl[1] !== 1'b1) begin bad++; $display("FAIL areset_refill_full got=%0b want=1", fl[1]); end
    for (int i = 0; i < 5; i++) begin
      re[1] = 1'b1;
      tick();
      total++; if (dout[1] !== 16'h0A00 + 16'(i)) begin bad++; $display("FAIL areset_order[%0d] got=%0h want=%0h", i, dout[1], 16'h0A00 + 16'(i)); end
    end
    idle();
  endtask

  task automatic test_random();
    int depth, sz, pw;
    for (int c = 0; c < 600; c++) begin
      pw = ((c / 100) % 2 == 0) ? 75 : 25;
      for (int k = 0; k < 3; k++) begin
        we[k] = ($urandom % 100) < pw;
        re[k] = ($urandom % 100) < (100 - pw);
      end
      din = 16'($urandom);
      tick();
      for (int k = 0; k < 3; k++) begin
        depth = (k == 1) ? 5 : 8;
        sz = msize(k);
        total++; if (act_cnt(k) !== sz) begin bad++; $display("FAIL rnd_count[%0d] c=%0d got=%0d want=%0d", k, c, act_cnt(k), sz); end
        total++; if ({fl[k], em[k], af[k], ae[k]} !== {sz == depth, sz == 0, sz >= depth - 2, sz <= 1})
          begin bad++; $display("FAIL rnd_flags[%0d] c=%0d got=%b want=%b", k, c, {fl[k], em[k], af[k], ae[k]}, {sz == depth, sz == 0, sz >= depth - 2, sz <= 1}); end
        total++; if ({ack[k], ovf[k], udf[k]} !== {ack_e[k], ovf_e[k], udf_e[k]})
          begin bad++; $display("FAIL rnd_pulses[%0d] c=%0d got=%b want=%b", k, c, {ack[k], ovf[k], udf[k]}, {ack_e[k], ovf_e[k], udf_e[k]}); end
        if (k != 2) begin
          total++; if (dout[k] !== dout_e[k]) begin bad++; $display("FAIL rnd_data[%0d] c=%0d got=%0h want=%0h", k, c, dout[k], dout_e[k]); end
        end else if (sz > 0) begin
          total++; if (dout[k] !== mhead(k)) begin bad++; $display("FAIL rnd_fwft[%0d] c=%0d got=%0h want=%0h", k, c, dout[k], mhead(k)); end
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_fwft();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next-generation buffer the FIFO constrained-random environment drives. It adds configurable width, depth and almost-full/almost-empty thresholds to the existing write/read interface, plus non-power-of-two depth support, an occupancy count and an optional first-word-fall-through read mode. It sits between a producer issuing `wr_en`/`data_in` and a consumer issuing `rd_en`, with all status flags exposed for flow control.

## Interface
- `FIFO_WIDTH`, 16, data width in bits (≥1).
- `FIFO_DEPTH`, 8, number of entries (≥2; need not be a power of two).
- `AF_THRESH`, `FIFO_DEPTH-2`, almostfull asserts when count ≥ AF_THRESH (1..FIFO_DEPTH-1).
- `AE_THRESH`, 1, almostempty asserts when count ≤ AE_THRESH (0..FIFO_DEPTH-2).
- `FWFT`, 0, 0 = registered read (standard mode), 1 = first-word-fall-through.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  FIFO_WIDTH  write data.
- `wr_en`  in  1  write request.
- `rd_en`  in  1  read request.
- `data_out`  out  FIFO_WIDTH  read data.
- `wr_ack`  out  1  registered pulse: the previous cycle's write was accepted.
- `overflow`  out  1  registered pulse: the previous cycle's write was rejected.
- `underflow`  out  1  registered pulse: the previous cycle's read was rejected.
- `full`, `empty`, `almostfull`, `almostempty`  out  1  combinational decode of count.
- `count`  out  $clog2(FIFO_DEPTH+1)  current occupancy.

## Operation
- State: storage array, `wr_ptr` and `rd_ptr` (0..FIFO_DEPTH-1), `count`.
- Pointers advance by 1 per accepted access and wrap from FIFO_DEPTH-1 to 0; no power-of-two assumption.
- Write accepted: wr_en && (!full || rd_en). Accepted write stores `data_in` at `wr_ptr`.
- Read accepted: rd_en && !empty.
- Full with wr_en && rd_en: both accepted; count unchanged; the head is read before its slot is overwritten.
- Empty with wr_en && rd_en: only the write is accepted; underflow pulses.
- count: +1 for write only, −1 for read only, unchanged for both or neither.
- Flags: full = (count==FIFO_DEPTH); empty = (count==0); almostfull = (count ≥ AF_THRESH); almostempty = (count ≤ AE_THRESH).
- Standard mode (FWFT=0): on an accepted read, `data_out` registers `mem[rd_ptr]` and then holds until the next accepted read.
- FWFT mode: `data_out` = `mem[rd_ptr]` combinationally. It is valid whenever !empty and don't-care when empty. rd_en acknowledges (pops) the head.
- Rejected accesses change no storage, pointers or count.

## Timing
- Reset (rst_n low, asynchronous): pointers 0; count 0; data_out 0 (standard mode); wr_ack, overflow, underflow 0; empty 1; almostempty 1; full 0; almostfull 0. Storage is not cleared.
- Reset mid-operation discards all contents immediately. The first edge after rst_n rises behaves as for an empty FIFO.
- Write latency: data written at edge N is readable in the cycle after edge N. In FWFT it appears on `data_out` after edge N. In standard mode a read at edge N+1 presents it after edge N+1.
- Flags and count reflect the edge at which an access was accepted; there is no extra cycle of delay.
- wr_ack, overflow and underflow are single-cycle pulses, asserted for the cycle after the offending or accepted edge. They reassert on consecutive cycles if the condition repeats.

## Test plan
- Reset, then DEPTH=8, WIDTH=16: write 0x0001..0x0008 on consecutive cycles. Required:
  - wr_ack for each write;
  - almostfull from count=6;
  - full after the 8th write; count=8.
  - A 9th write gives overflow=1 and wr_ack=0; contents unchanged.
- From full, read 8 times in standard mode. Required:
  - data_out 0x0001..0x0008, each one cycle after its rd_en;
  - almostempty at count ≤ 1; empty at count 0.
  - A 9th read gives underflow=1 and data_out holds 0x0008.
- DEPTH=5 (non-power-of-two): 3 writes, 3 reads, then 5 writes and 5 reads. Required: the pointers wrap correctly and data returns in order (wrap at index 4→0).
- Simultaneous access:
  - When full with wr_en && rd_en: count stays 8, the head is popped, the new word is enqueued and wr_ack=1.
  - When empty with wr_en && rd_en: count becomes 1 and underflow=1.
- FWFT=1: write 0xABCD into empty. Required:
  - data_out=0xABCD and empty=0 in the next cycle, with no rd_en.
  - rd_en pops it, then empty=1.
- Assert rst_n low asynchronously (between edges) at count=4. Required: outputs go to their reset values without waiting for a clock edge, and the next write lands at index 0.
